// File: rtl/div_pkg.sv
// div_pkg: shared constants and FSM state encoding for the sequential divider.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;
endpackage

// File: rtl/adder_subtractor.sv
// adder_subtractor: W-bit ripple-style adder; sub inverts b so a - b needs cin=1.
module adder_subtractor #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, sub ? ~b : b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/div_step.sv
// div_step: one restoring-division step (shift in dividend bit, trial subtract, select).
module div_step
    import div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem,
    input  logic                 dq_msb,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] rem_nx,
    output logic                 qbit
);
    logic [DIV_WIDTH-1:0] shifted, diff;
    logic                 cout;
    assign shifted = {rem[DIV_WIDTH-2:0], dq_msb};
    adder_subtractor #(.W(DIV_WIDTH)) u_sub (
        .a(shifted), .b(divisor), .sub(1'b1), .cin(1'b1), .sum(diff), .cout(cout)
    );
    // rem's top bit is the shifted-out 33rd bit, so the trial subtract always fits then
    assign qbit   = rem[DIV_WIDTH-1] | cout;
    assign rem_nx = qbit ? diff : shifted;
endmodule

// File: rtl/div_seq32.sv
// div_seq32: 32-cycle restoring divider with FIXUP and DONE stages.
// Define DIV_SIGNED_EN for two's-complement operands (truncating quotient, remainder follows dividend).
module div_seq32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             result_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             exception
);
    state_t           state, state_nx;
    logic [4:0]       count;
    logic [WIDTH-1:0] rem, dq, dvs, rem_nx;
    logic [WIDTH-1:0] dividend_mag, divisor_mag, q_fix, r_fix;
    logic             qbit, div_zero;
    assign div_zero = divisor == '0;
`ifdef DIV_SIGNED_EN
    logic             q_neg, r_neg;
    logic [WIDTH-1:0] neg_a, neg_b;
    logic [1:0]       neg_cout_unused;
    // Both negators are shared: operand magnitudes in IDLE, result sign fix in FIXUP
    adder_subtractor #(.W(WIDTH)) u_neg_a (
        .a('0), .b(state == IDLE ? dividend : dq), .sub(1'b1), .cin(1'b1),
        .sum(neg_a), .cout(neg_cout_unused[0])
    );
    adder_subtractor #(.W(WIDTH)) u_neg_b (
        .a('0), .b(state == IDLE ? divisor : rem), .sub(1'b1), .cin(1'b1),
        .sum(neg_b), .cout(neg_cout_unused[1])
    );
    assign dividend_mag = dividend[WIDTH-1] ? neg_a : dividend;
    assign divisor_mag  = divisor[WIDTH-1] ? neg_b : divisor;
    assign q_fix        = q_neg ? neg_a : dq;
    assign r_fix        = r_neg ? neg_b : rem;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == IDLE && start) begin
            q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg <= dividend[WIDTH-1];
        end
    end
`else
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
    assign q_fix        = dq;
    assign r_fix        = rem;
`endif
    div_step u_step (.rem(rem), .dq_msb(dq[WIDTH-1]), .divisor(dvs), .rem_nx(rem_nx), .qbit(qbit));
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end
    always_comb begin
        state_nx     = state == IDLE  ? (start ? (div_zero ? DONE : ITER) : IDLE) :
                       state == ITER  ? (count == 5'(DIV_ITERS - 1) ? FIXUP : ITER) :
                       state == FIXUP ? DONE : IDLE;
        busy         = state == ITER || state == FIXUP;
        result_ready = state == DONE;
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count     <= '0;
            rem       <= '0;
            dq        <= '0;
            dvs       <= '0;
            quotient  <= '0;
            remainder <= '0;
            exception <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (div_zero) begin
                        quotient  <= '0;
                        remainder <= dividend;
                        exception <= 1'b1;
                    end else begin
                        rem   <= '0;
                        dq    <= dividend_mag;
                        dvs   <= divisor_mag;
                        count <= '0;
                    end
                end
                ITER: begin
                    rem   <= rem_nx;
                    dq    <= {dq[WIDTH-2:0], qbit};
                    count <= count + 5'd1;
                end
                FIXUP: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    exception <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq32.sv
// tb_div_seq32: scoreboard bench for div_seq32; signed cases enabled by DIV_SIGNED_EN.
module tb_div_seq32;
    logic        clock = 0, reset_n = 0, start = 0;
    logic [31:0] dividend = 0, divisor = 0;
    logic        busy, result_ready, exception;
    logic [31:0] quotient, remainder;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int vectors = 0, miscompares = 0;

    div_seq32 dut (
        .clock(clock), .reset_n(reset_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .result_ready(result_ready), .quotient(quotient), .remainder(remainder),
        .exception(exception)
    );

    always #5 clock = ~clock;

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
`ifdef DIV_SIGNED_EN
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
`else
        q = a / b;
        r = a % b;
`endif
    endfunction

    // Leaves the bench at the falling edge of cycle 1 (cycle 0 = accepting edge)
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input logic e);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1;
        sb.push_back('{q, r, e, (b == 0) ? 1 : 34});
        @(negedge clock);
        start = 0;
    endtask

    task automatic send_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        model(a, b, q, r);
        send(a, b, q, r, 1'b0);
    endtask

    task automatic collect(input string name, input bit poke_done);
        exp_t x;
        bit   seen = 0;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        x = sb.pop_front();
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            if (cyc > 1) @(negedge clock);
            vectors++;
            if (busy !== (cyc < x.lat)) begin
                miscompares++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, cyc, busy, cyc < x.lat);
            end
            if (result_ready === 1'b1) begin
                seen = 1;
                vectors++;
                if (cyc != x.lat || quotient !== x.q || remainder !== x.r || exception !== x.e) begin
                    miscompares++;
                    $display("FAIL %s result: got cyc=%0d q=%h r=%h e=%b want cyc=%0d q=%h r=%h e=%b",
                             name, cyc, quotient, remainder, exception, x.lat, x.q, x.r, x.e);
                end
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: result_ready not seen in 40 cycles", name);
        end else begin
            if (poke_done) begin
                dividend = 32'd9;
                divisor  = 32'd3;
                start    = 1;
            end
            @(negedge clock);
            start = 0;
            vectors++;
            if (result_ready !== 1'b0 || busy !== 1'b0 || quotient !== x.q || remainder !== x.r ||
                exception !== x.e) begin
                miscompares++;
                $display("FAIL %s hold: got rdy=%b busy=%b q=%h r=%h e=%b want rdy=0 busy=0 q=%h r=%h e=%b",
                         name, result_ready, busy, quotient, remainder, exception, x.q, x.r, x.e);
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 0;
        repeat (3) @(negedge clock);
        vectors++;
        if (busy !== 0 || result_ready !== 0 || quotient !== 0 || remainder !== 0 || exception !== 0) begin
            miscompares++;
            $display("FAIL reset: got busy=%b rdy=%b q=%h r=%h e=%b want all 0",
                     busy, result_ready, quotient, remainder, exception);
        end
        reset_n = 1;
    endtask

    task automatic test_divide;
        send(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        collect("100/7", 0);
`ifdef DIV_SIGNED_EN
        send(-32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        collect("-7/2", 0);
        send(32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1, 1'b0);
        collect("7/-2", 0);
        send(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        collect("min/-1", 0);
        send_model(32'hFFFF_FFFF, 32'h8000_0000);
        collect("-1/min", 0);
`else
        send(32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0);
        collect("max/2^31", 0);
        send(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        collect("2^31/max", 0);
`endif
        send_model(32'd0, 32'd1);
        collect("0/1", 0);
        send_model(32'hFFFF_FFFF, 32'd1);
        collect("max/1", 0);
        send_model(32'd3, 32'hFFFF_FFFF);
        collect("3/max", 0);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 0) b = 1;
            send_model(a, b);
            collect("random", 0);
        end
    endtask

    task automatic test_div_zero;
        send(32'd5, 32'd0, 32'd0, 32'd5, 1'b1);
        collect("5/0", 0);
        send(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        collect("exc_clear", 0);
    endtask

    task automatic test_ignore_start;
        send(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        fork
            collect("ignore_busy", 0);
            begin
                repeat (9) @(negedge clock);
                dividend = 32'd9;
                divisor  = 32'd3;
                start    = 1;
                @(negedge clock);
                start = 0;
            end
        join
    endtask

    task automatic test_back_to_back;
        send(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        collect("start_in_done", 1);
        send(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        collect("back_to_back", 0);
    endtask

    task automatic test_reset_midop;
        send(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (9) @(negedge clock);
        reset_n = 0;
        @(negedge clock);
        vectors++;
        if (busy !== 0 || result_ready !== 0 || quotient !== 0 || remainder !== 0 || exception !== 0) begin
            miscompares++;
            $display("FAIL reset_midop: got busy=%b rdy=%b q=%h r=%h e=%b want all 0",
                     busy, result_ready, quotient, remainder, exception);
        end
        reset_n = 1;
        sb.delete();
        send(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        collect("after_reset", 0);
    endtask

    initial begin
        test_reset;
        test_divide;
        test_div_zero;
        test_ignore_start;
        test_back_to_back;
        test_reset_midop;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/div_seq32.md
# div_seq32

Iterative 32-bit restoring divider for the ALU datapath. It accepts a dividend/divisor pair on a one-cycle start strobe and runs one subtract-and-shift step per clock through a 32-bit adder_subtractor in subtract mode. It returns a 32-bit quotient and remainder with a one-cycle ready pulse. It sits beside the adder and feeds it operands each cycle, serving the ALU's DIV/REM operations.

## Interface
- WIDTH, 32: operand width. Fixed at 32; the parameter is documentation only.
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clock.
- start  in  1  one-cycle request strobe. Honoured only in IDLE.
- dividend  in  32  sampled on the edge where start is accepted.
- divisor  in  32  sampled on the edge where start is accepted.
- busy  out  1  high from the cycle after acceptance until result_ready.
- result_ready  out  1  one-cycle pulse; quotient, remainder and exception are valid in this cycle.
- quotient  out  32  held until the next accepted start.
- remainder  out  32  held until the next accepted start.
- exception  out  1  divide-by-zero flag; held like the data outputs.

## Operation
- States:
  - IDLE: wait for start.
  - ITER: 32 cycles, 5-bit counter 0..31.
  - FIXUP: 1 cycle, sign correction.
  - DONE: 1 cycle; result_ready=1.
- IDLE, start=1, divisor≠0:
  - Latch operand magnitudes.
  - rem=0, dq=dividend magnitude, count=0.
  - Go to ITER.
- IDLE, start=1, divisor=0:
  - quotient=0, remainder=dividend, exception=1.
  - Go to DONE, skipping ITER and FIXUP.
- ITER step:
  - shifted={rem[30:0],dq[31]}, out_bit=rem[31].
  - diff=shifted−divisor_mag, computed as adder cin=1 with cout.
  - If out_bit|cout: rem=diff, new q bit=1. Otherwise rem=shifted, q bit=0.
  - dq={dq[30:0],qbit}.
  - out_bit covers the 33rd remainder bit, so divisors ≥ 2^31 are handled with a 32-bit adder.
- After count=31, go to FIXUP.
- FIXUP applies sign rules (see Configuration), writes quotient/remainder/exception=0, then goes to DONE.
- DONE: result_ready=1, busy=0, then go to IDLE.
- start outside IDLE is ignored, including start in DONE; no queueing.
- reset_n=0 on any edge:
  - state=IDLE, counter=0.
  - busy=0, result_ready=0, quotient=0, remainder=0, exception=0.
  - Any operation in flight is abandoned.

## Timing
- start accepted at edge of cycle 0.
- busy=1 in cycles 1..33; ITER occupies cycles 1..32, FIXUP cycle 33.
- result_ready=1 in cycle 34.
- Next start is accepted no earlier than cycle 35.
- Divide-by-zero: result_ready=1 in cycle 1, busy stays 0.
- Latency is data-independent. It is identical with and without the configuration macro.
- Outputs change only on the edge entering DONE, or on reset.

## Configuration
- DIV_SIGNED_EN defined: operands are two's complement.
  - Magnitudes are taken on acceptance.
  - Quotient is negated if the operand signs differ; it truncates toward zero.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, exception 0 (wraps).
- DIV_SIGNED_EN undefined: unsigned only. No magnitude conversion; FIXUP passes values through unchanged.

## Structure
- Package div_pkg holds:
  - state enum (IDLE, ITER, FIXUP, DONE);
  - DIV_WIDTH=32;
  - DIV_ITERS=32.
- Sub-module div_step (combinational): instantiates adder_subtractor with cin=1 and outputs next rem and qbit.
- Sign negation in div_seq32 reuses the same adder form (0 − x, cin=1).

## Test plan
- Unsigned 100/7, start at cycle 0 -> quotient=14, remainder=2, exception=0, result_ready only in cycle 34.
- 0xFFFFFFFF/0x80000000 (unsigned build) -> quotient=1, remainder=0x7FFFFFFF, exercising the out_bit path.
- DIV_SIGNED_EN: −7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also 7/−2 -> quotient=0xFFFFFFFD, remainder=1.
- 5/0 -> exception=1, quotient=0, remainder=5, result_ready in cycle 1, busy never high.
- Start 100/7, pulse start with 9/3 at cycle 10 -> second request ignored; result is 14/2 at cycle 34.
- Start 100/7, reset_n=0 at cycle 10 -> next cycle busy=0 and all outputs 0. A new start of 9/3 then gives quotient 3, remainder 0 after 34 cycles.
